// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and flush controller for the five-stage pipeline.
// Shadows the destination registers of EXE/MEM/WB and derives bubbles, flushes and forwarding selects.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             mem_busy,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_b,
  input  logic [3:0]       id_dest,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       mr;
    logic       b;
  } slot_t;

  typedef struct packed {
    slot_t      base;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
  } slot_e_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_MEM = 2'd1,
    SEL_WB  = 2'd2
  } fwd_sel_t;

  slot_e_t e_q;
  slot_t   m_q;
  slot_t   w_q;
  slot_e_t e_issue;
  logic    dep_e;
  logic    dep_m;
  logic    raw_hazard;
  logic    issue;

  // M.b and the W-stage mr/b are shadowed for completeness but never consulted.
  logic unused_fields;
  assign unused_fields = ^{m_q.b, w_q.mr, w_q.b};

  function automatic logic match(input logic [3:0] r, input slot_t s);
    return s.v && (s.dest == r);
  endfunction

  function automatic fwd_sel_t pick_src(input logic en, input logic [3:0] r,
                                        input slot_t m, input slot_t w);
    // A load in MEM has no data yet, so only WB may supply it.
    if (en && match(r, m) && !m.mr)
      return SEL_MEM;
    else if (en && match(r, w))
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  // NOTE: every output of a combinational block is defaulted first so no path can infer a latch.
  always_comb begin
    dep_e      = 1'b0;
    dep_m      = 1'b0;
    raw_hazard = 1'b0;
    flush      = 1'b0;
    hazard     = 1'b0;
    freeze     = 1'b0;
    issue      = 1'b0;
    fwd_sel_a  = SEL_RF;
    fwd_sel_b  = SEL_RF;

    dep_e      = match(id_src1, e_q.base) | (id_two_src & match(id_src2, e_q.base));
    dep_m      = match(id_src1, m_q)      | (id_two_src & match(id_src2, m_q));
    raw_hazard = fwd_en ? (dep_e & e_q.base.mr) : (dep_e | dep_m);

    flush  = e_q.base.b;
    hazard = raw_hazard & ~flush;
    freeze = hazard | mem_busy;
    issue  = ~hazard & ~flush & ~mem_busy;

    fwd_sel_a = pick_src(fwd_en, e_q.s1, m_q, w_q);
    fwd_sel_b = pick_src(fwd_en & e_q.two, e_q.s2, m_q, w_q);
  end

  always_comb begin
    e_issue.base.v    = id_wb_en;
    e_issue.base.dest = id_dest;
    e_issue.base.mr   = id_mem_r_en;
    e_issue.base.b    = id_b;
    e_issue.s1        = id_src1;
    e_issue.s2        = id_src2;
    e_issue.two       = id_two_src;
  end

  // NOTE: state is updated with non-blocking assignments so all slots shift from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= '0;
      m_q       <= '0;
      w_q       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      e_q <= issue ? e_issue : '0;
      m_q <= e_q.base;
      w_q <= m_q;
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-scenario tasks with a queue of expected control vectors.
// A second instance with a 2-bit counter width exercises saturation on the same stimulus.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       r;
    logic       busy;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       two;
    logic       wb;
    logic       mr;
    logic       b;
    logic [3:0] dest;
  } stim_t;

  localparam logic [6:0] C0 = 7'b000_00_00;
  localparam logic [6:0] HZ = 7'b110_00_00;
  localparam logic [6:0] FL = 7'b001_00_00;
  localparam logic [6:0] BZ = 7'b010_00_00;

  logic        clk = 1'b0;
  logic        rst;
  logic        fwd_en;
  logic        mem_busy;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        id_b;
  logic [3:0]  id_dest;
  logic        hazard, freeze, flush;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_hazard, s_freeze, s_flush;
  logic [1:0]  s_fwd_sel_a, s_fwd_sel_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  logic [6:0]  ctl;

  int checks = 0;
  int passed = 0;
  logic [6:0] exp_q[$];

  assign ctl = {hazard, freeze, flush, fwd_sel_a, fwd_sel_b};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .mem_busy(mem_busy),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_b(id_b), .id_dest(id_dest),
    .hazard(hazard), .freeze(freeze), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .mem_busy(mem_busy),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_b(id_b), .id_dest(id_dest),
    .hazard(s_hazard), .freeze(s_freeze), .flush(s_flush),
    .fwd_sel_a(s_fwd_sel_a), .fwd_sel_b(s_fwd_sel_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic stim_t ins(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                                input logic wb, input logic mr, input logic b,
                                input logic [3:0] dest, input logic busy = 1'b0,
                                input logic r = 1'b0);
    stim_t s;
    s.r = r; s.busy = busy; s.s1 = s1; s.s2 = s2; s.two = two;
    s.wb = wb; s.mr = mr; s.b = b; s.dest = dest;
    return s;
  endfunction

  function automatic stim_t nop(input logic busy = 1'b0);
    return ins(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, busy);
  endfunction

  // Apply one instruction just after the rising edge; it is seen by the following edge.
  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    rst         = s.r;
    mem_busy    = s.busy;
    id_src1     = s.s1;
    id_src2     = s.s2;
    id_two_src  = s.two;
    id_wb_en    = s.wb;
    id_mem_r_en = s.mr;
    id_b        = s.b;
    id_dest     = s.dest;
  endtask

  task automatic do_reset();
    drive(ins(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1));
  endtask

  task automatic test_reset();
    logic [6:0] want;
    rst = 1'b1; fwd_en = 1'b0; mem_busy = 1'b0;
    id_src1 = 4'd3; id_src2 = 4'd3; id_two_src = 1'b1;
    id_wb_en = 1'b1; id_mem_r_en = 1'b0; id_b = 1'b0; id_dest = 4'd3;
    repeat (2) @(posedge clk);
    exp_q.push_back(C0);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (ctl !== want) $display("FAIL reset_ctl got=%b want=%b", ctl, want); else passed++;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); else passed++;
    checks++;
    if (flush_cnt !== 16'd0) $display("FAIL reset_flush_cnt got=%0d want=0", flush_cnt); else passed++;

    drive(ins(4'd1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4));
    exp_q.push_back(C0);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (ctl !== want) $display("FAIL reset_indep0 got=%b want=%b", ctl, want); else passed++;
    drive(nop());
    exp_q.push_back(C0);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (ctl !== want) $display("FAIL reset_indep1 got=%b want=%b", ctl, want); else passed++;
  endtask

  task automatic test_raw_nofwd();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    stim_t      p, c;
    fwd_en = 1'b0;
    do_reset();
    p = ins(4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    c = ins(4'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    // Tail: register 0 as an ordinary destination, consumed through src2.
    st = {p, c, c, c, nop(),
          ins(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0),
          ins(4'd15, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9)};
    ex = {C0, HZ, HZ, C0, C0, C0, HZ};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL raw_nofwd[%0d] got=%b want=%b", i, ctl, want); else passed++;
    end
    checks++;
    if (stall_cnt !== 16'd2) $display("FAIL raw_nofwd_stall_cnt got=%0d want=2", stall_cnt); else passed++;
    checks++;
    if (flush_cnt !== 16'd0) $display("FAIL raw_nofwd_flush_cnt got=%0d want=0", flush_cnt); else passed++;
  endtask

  task automatic test_load_use();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    fwd_en = 1'b1;
    do_reset();
    st = {ins(4'd8, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5),
          ins(4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7),
          ins(4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7),
          nop()};
    ex = {C0, HZ, C0, 7'b000_00_10};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL load_use[%0d] got=%b want=%b", i, ctl, want); else passed++;
    end
    checks++;
    if (stall_cnt !== 16'd1) $display("FAIL load_use_stall_cnt got=%0d want=1", stall_cnt); else passed++;

    // ALU producer: no stall, MEM forwarding; then a one-source op must not forward on src2.
    do_reset();
    st = {ins(4'd8, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5),
          ins(4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7),
          ins(4'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0),
          nop()};
    ex = {C0, C0, 7'b000_01_01, C0};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL alu_fwd[%0d] got=%b want=%b", i, ctl, want); else passed++;
    end
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL alu_fwd_stall_cnt got=%0d want=0", stall_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    fwd_en = 1'b1;
    do_reset();
    // Two writers of r5 back to back: the younger one in MEM must win over WB.
    st = {ins(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5),
          ins(4'd8, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5),
          ins(4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0),
          nop(), nop()};
    ex = {C0, C0, C0, 7'b000_01_01, C0};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL back_to_back[%0d] got=%b want=%b", i, ctl, want); else passed++;
    end
  endtask

  task automatic test_branch();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    fwd_en = 1'b0;
    do_reset();
    st = {ins(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4),
          ins(4'd4, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9),
          ins(4'd9, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10),
          nop()};
    ex = {C0, FL, C0, C0};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL branch[%0d] got=%b want=%b", i, ctl, want); else passed++;
    end
    checks++;
    if (flush_cnt !== 16'd1) $display("FAIL branch_flush_cnt got=%0d want=1", flush_cnt); else passed++;
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL branch_stall_cnt got=%0d want=0", stall_cnt); else passed++;
  endtask

  task automatic test_mem_busy();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    stim_t      c, cb;
    fwd_en = 1'b0;
    do_reset();
    c  = ins(4'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
    cb = ins(4'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1);
    st = {ins(4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3),
          c, cb, cb, cb, c, c, nop(1'b1), nop()};
    ex = {C0, HZ, HZ, HZ, HZ, HZ, C0, BZ, C0};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL mem_busy[%0d] got=%b want=%b", i, ctl, want); else passed++;
      if (i == 4) begin
        checks++;
        if (stall_cnt !== 16'd1) $display("FAIL mem_busy_hold_cnt got=%0d want=1", stall_cnt); else passed++;
      end
    end
    checks++;
    if (stall_cnt !== 16'd2) $display("FAIL mem_busy_stall_cnt got=%0d want=2", stall_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    fwd_en = 1'b0;
    do_reset();
    st = {ins(4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3),
          ins(4'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1),
          ins(4'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6)};
    ex = {C0, HZ, C0};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL reset_mid[%0d] got=%b want=%b", i, ctl, want); else passed++;
    end
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_mid_stall_cnt got=%0d want=0", stall_cnt); else passed++;
  endtask

  task automatic test_saturation();
    stim_t      st[$];
    logic [6:0] ex[$];
    logic [6:0] want;
    stim_t      b, c, d;
    fwd_en = 1'b0;
    do_reset();
    b = ins(4'd1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    c = ins(4'd2, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    d = ins(4'd3, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
    st = {ins(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1), b, b, b, c, c, c, d, d};
    ex = {C0, HZ, HZ, C0, HZ, HZ, C0, HZ, HZ};
    foreach (st[i]) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (ctl !== want) $display("FAIL saturation[%0d] got=%b want=%b", i, ctl, want); else passed++;
      if (i == 5) begin
        checks++;
        if (s_stall_cnt !== 2'd3) $display("FAIL sat_cnt_after3 got=%0d want=3", s_stall_cnt); else passed++;
      end
    end
    checks++;
    if (s_stall_cnt !== 2'd3) $display("FAIL sat_cnt_after5 got=%0d want=3", s_stall_cnt); else passed++;
    checks++;
    if (stall_cnt !== 16'd5) $display("FAIL wide_cnt_after5 got=%0d want=5", stall_cnt); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw_nofwd();
    test_load_use();
    test_back_to_back();
    test_branch();
    test_mem_busy();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Scoreboard-based hazard, stall and flush controller for the five-stage ARM-subset pipeline. It keeps a shadow copy of the in-flight destination registers for the EXE, MEM and WB stages, and drives the decode stage's `hazard` input and the IF/ID freeze. It also squashes the two younger instructions when a branch reaches EXE and produces operand-forwarding selects for the EXE stage. Memory-busy back-pressure freezes the whole pipeline and the scoreboard together.

## Interface
- `CNT_W`, default 16: width of the saturating stall and flush event counters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fwd_en`  in  1  1 = forwarding enabled (only load-use stalls); 0 = stall on any RAW dependency.
- `mem_busy`  in  1  data memory not ready; the whole pipeline holds.
- `id_src1`, `id_src2`  in  4 each  source registers of the instruction in ID.
- `id_two_src`  in  1  `id_src2` is a real operand.
- `id_wb_en`, `id_mem_r_en`, `id_b`  in  1 each  decoded, condition-qualified controls of the instruction in ID.
- `id_dest`  in  4  destination register of the instruction in ID.
- `hazard`  out  1  to the decode stage; zeroes its control outputs (bubble).
- `freeze`  out  1  holds the PC and the IF/ID register.
- `flush`  out  1  clears the IF/ID and ID/EXE registers.
- `fwd_sel_a`, `fwd_sel_b`  out  2 each  EXE operand source: 0 = register file, 1 = MEM-stage result, 2 = WB-stage result; 3 is never driven.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  event counters.

## Operation
- Shadow slots E, M, W. Each slot holds `v`, `dest[3:0]`, `mr` and `b`; slot E additionally holds `s1[3:0]`, `s2[3:0]` and `two`.
- **Issue condition.** Issue = ~hazard & ~flush & ~mem_busy. On issue, slot E loads `v=id_wb_en`, `dest=id_dest`, `mr=id_mem_r_en`, `b=id_b`, `s1=id_src1`, `s2=id_src2`, `two=id_two_src`.
- **Bubble.** If ~mem_busy and no issue, slot E loads a bubble: all fields 0.
- **Advance.** If ~mem_busy: W<=M and M<=E.
- **mem_busy=1.** All slots and both counters hold. Outputs still reflect the held state. `freeze`=1.
- **match(r, X)** = X.v & (X.dest==r).
- **dep(X)** = match(id_src1, X) | (id_two_src & match(id_src2, X)).
- **hazard, fwd_en=0:** dep(E) | dep(M).
- **hazard, fwd_en=1:** dep(E) & E.mr (load-use only).
- **hazard gating:** forced 0 whenever `flush`=1.
- **flush** = E.b (a branch in EXE is always taken, because the condition was already applied in ID). Slot E's `b` is cleared at the next advance like every other field, so `flush` lasts exactly one non-busy cycle.
- **freeze** = hazard | mem_busy.
- **fwd_sel_a:** 1 if fwd_en & match(E.s1, M) & ~M.mr; else 2 if fwd_en & match(E.s1, W); else 0.
- **fwd_sel_b:** same rule using E.s2, additionally gated by E.two.
- **Why M.mr is excluded from MEM forwarding:** load data is not available in MEM. Fall back to W; the load-use stall guarantees correctness.
- **Counters.** `stall_cnt` increments each cycle with hazard=1 and mem_busy=0. `flush_cnt` increments each cycle with flush=1 and mem_busy=0. Both saturate at all-ones.

## Timing
- **Reset.** Reset clears every slot field and both counters. After reset: `hazard`, `freeze`, `flush` = 0; `fwd_sel_*` = 0; counters = 0. `mem_busy` is ignored during reset.
- **Output timing.** `hazard`, `freeze`, `flush` and `fwd_sel_*` are combinational from slots and inputs, valid in the same cycle. Slots and counters are registered, with one-cycle latency.
- **Load-use stall length.**
  - fwd_en=1: exactly 1 bubble.
  - fwd_en=0: 2 bubbles if the producer is in E, 1 bubble if it is in M.
- **Branch.** A branch issued at cycle t is in E at t+1, where `flush`=1. The instruction in ID at t+1 is not recorded.
- **Branch plus hazard.** If a branch and a hazard coincide, flush wins: hazard=0 and the slot E bubble is loaded.
- **Register 0** is an ordinary register: no special case.
- **mem_busy raised mid-stall.** The stall extends without double-counting.
- **Reset asserted mid-operation.** It discards in-flight state in one cycle.

## Test plan
- **Reset.** Hold `rst` for 2 cycles with `id_wb_en`=1 → all outputs 0. Then `rst`=0 with an independent instruction → no hazard.
- **RAW, fwd_en=0.** Issue `dest`=3, then `src1`=3 → `hazard`=`freeze`=1 for 2 cycles, then the consumer issues. `stall_cnt`=2.
- **Load-use, fwd_en=1.** Issue a load (`mr`=1) to `dest`=5, then `src2`=5 with `two_src`=1.
  - Expect 1 stall cycle.
  - When the consumer is in EXE, expect `fwd_sel_b`=2.
  - An ALU producer instead gives 0 stalls and `fwd_sel_b`=1.
- **Branch.** Issue `id_b`=1 → `flush`=1 for exactly the next cycle and `flush_cnt`=1. A dependent instruction in ID that cycle gives `hazard`=0 and is not recorded.
- **mem_busy.** Raise `mem_busy` for 3 cycles during a pending dependency → `freeze`=1 and slots unchanged throughout. After release, the stall resumes with the original remaining length.
- **Counter saturation.** With `CNT_W`=2, force 5 stall cycles → `stall_cnt` ends at 3.
